// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, bit positions, operation/state enums and the RMW helper.
package csr_pkg;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] VEC_OFFSET    = 32'd28;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MTIE_BIT = 7;
    localparam int MTIP_BIT = 7;
    typedef enum logic [1:0] {NONE, WRITE, SET, CLEAR} csr_op_e;
    typedef enum logic {RUN, FLUSH} trap_state_e;
    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_v, input logic [31:0] wdata);
        return op == WRITE ? wdata : op == SET ? (old_v | wdata) : op == CLEAR ? (old_v & ~wdata) : old_v;
    endfunction
endpackage

// File: rtl/csr_trap_fsm.sv
// csr_trap_fsm: RUN/FLUSH tracking, interrupt vs MRET arbitration and redirect target.
module csr_trap_fsm import csr_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_is_mret,
    input  logic        i_mie,
    input  logic        i_mtie,
    input  logic        i_mtip,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_run,
    output logic        o_irq_take,
    output logic        o_mret_take,
    output logic        o_epc_taken,
    output logic [31:0] o_excp_pc
);
    trap_state_e r_state, w_next;
    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else r_state <= w_next;
    end
    always_comb begin
        o_run = r_state == RUN;
        o_mret_take = i_valid & i_is_mret & o_run;
        o_irq_take = i_valid & ~i_is_mret & o_run & i_mie & i_mtie & i_mtip;
        o_epc_taken = o_irq_take | o_mret_take;
        w_next = o_epc_taken ? FLUSH : RUN;
        o_excp_pc = o_mret_take ? i_mepc :
                    o_irq_take ? (i_mtvec & ~32'h3) + (i_mtvec[0] ? VEC_OFFSET : 32'd0) : '0;
    end
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, read mux and timer-interrupt trap entry/return.
// Defining CSR_MCYCLE_EN adds the 64-bit mcycle counter at 0xB00/0xB80.
module csr_file import csr_pkg::*; #(
    parameter logic [31:0] RESET_MTVEC     = 32'h0000_0000,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        csr_rd,
    input  logic        csr_wr,
    input  logic        is_mret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] pc,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] excp_pc
);
    logic [IRQ_SYNC_STAGES-1:0] r_sync;
    logic [IRQ_SYNC_STAGES:0]   w_sync_in;
    logic        r_mie, r_mpie, r_mtie;
    logic [31:0] r_mtvec, r_mepc, r_mcause;
    logic        w_valid, w_run, w_irq_take, w_mret_take, w_wr_en, w_mtip;
    logic [31:0] w_old, w_new;
`ifdef CSR_MCYCLE_EN
    logic [63:0] r_mcycle, w_cyc_inc;
`endif
    assign w_sync_in = {r_sync, timer_irq};
    assign w_mtip = r_sync[IRQ_SYNC_STAGES-1];
    assign w_valid = instr_valid & ~rst;
    csr_trap_fsm u_fsm (
        .clk(clk), .rst(rst), .i_valid(w_valid), .i_is_mret(is_mret),
        .i_mie(r_mie), .i_mtie(r_mtie), .i_mtip(w_mtip), .i_mtvec(r_mtvec), .i_mepc(r_mepc),
        .o_run(w_run), .o_irq_take(w_irq_take), .o_mret_take(w_mret_take),
        .o_epc_taken(epc_taken), .o_excp_pc(excp_pc)
    );
    always_comb begin
        w_old = '0;
        case (csr_addr)
            ADDR_MSTATUS: w_old = 32'(r_mie) << MIE_BIT | 32'(r_mpie) << MPIE_BIT;
            ADDR_MIE:     w_old = 32'(r_mtie) << MTIE_BIT;
            ADDR_MIP:     w_old = 32'(w_mtip) << MTIP_BIT;
            ADDR_MTVEC:   w_old = r_mtvec;
            ADDR_MEPC:    w_old = r_mepc;
            ADDR_MCAUSE:  w_old = r_mcause;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:  w_old = r_mcycle[31:0];
            ADDR_MCYCLEH: w_old = r_mcycle[63:32];
`endif
            default:      w_old = '0;
        endcase
        csr_rdata = (csr_rd & w_valid) ? w_old : '0;
        w_new = csr_apply(csr_op_e'(csr_op), w_old, csr_wdata);
        // The instruction in MEM during FLUSH is wrong-path, and an interrupted one re-executes later.
        w_wr_en = csr_wr & w_valid & w_run & ~w_irq_take & ~w_mret_take & (csr_op_e'(csr_op) != NONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtie   <= 1'b0;
            r_mtvec  <= RESET_MTVEC & ~32'h2;
            r_mepc   <= '0;
            r_mcause <= '0;
        end else begin
            r_sync <= w_sync_in[IRQ_SYNC_STAGES-1:0];
            if (w_irq_take) begin
                r_mepc   <= pc & ~32'h3;
                r_mcause <= CAUSE_M_TIMER;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_mret_take) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr_en) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        r_mie  <= w_new[MIE_BIT];
                        r_mpie <= w_new[MPIE_BIT];
                    end
                    ADDR_MIE:    r_mtie   <= w_new[MTIE_BIT];
                    ADDR_MTVEC:  r_mtvec  <= w_new & ~32'h2;
                    ADDR_MEPC:   r_mepc   <= w_new & ~32'h3;
                    ADDR_MCAUSE: r_mcause <= w_new;
                    default: ;
                endcase
            end
        end
    end
`ifdef CSR_MCYCLE_EN
    assign w_cyc_inc = r_mcycle + 64'd1;
    always_ff @(posedge clk) begin
        if (rst) r_mcycle <= '0;
        else begin
            r_mcycle[31:0]  <= (w_wr_en && csr_addr == ADDR_MCYCLE) ? w_new : w_cyc_inc[31:0];
            r_mcycle[63:32] <= (w_wr_en && csr_addr == ADDR_MCYCLEH) ? w_new : w_cyc_inc[63:32];
        end
    end
`endif
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboarded random + directed bench for csr_file against an abstract CSR model.
module tb_csr_file;
    logic        clk = 1'b0;
    logic        rst, instr_valid, csr_rd, csr_wr, is_mret, timer_irq;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, pc, csr_rdata, excp_pc;
    logic        epc_taken;
    always #5 clk = ~clk;
    csr_file dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .csr_rd(csr_rd), .csr_wr(csr_wr),
        .is_mret(is_mret), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .pc(pc), .timer_irq(timer_irq), .csr_rdata(csr_rdata), .epc_taken(epc_taken), .excp_pc(excp_pc)
    );
    typedef struct {
        logic [31:0] rdata;
        logic        epc;
        logic [31:0] tgt;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    bit [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    bit [63:0] m_cyc;
    bit        m_flush;
    bit        hist[$];
    bit        t_lvl;
    bit [11:0] addrs[10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h000};
    function automatic bit [31:0] m_read(bit [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h344: return hist[0] ? 32'h80 : 32'h0;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef CSR_MCYCLE_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction
    task automatic step(input bit r, input bit iv, input bit rd, input bit wr, input bit mret,
                        input bit [1:0] op, input bit [11:0] a, input bit [31:0] wd, input bit [31:0] p, input bit t);
        exp_t e;
        bit v, ti, tm;
        bit [31:0] nv;
        @(negedge clk);
        rst = r; instr_valid = iv; csr_rd = rd; csr_wr = wr; is_mret = mret;
        csr_op = op; csr_addr = a; csr_wdata = wd; pc = p; timer_irq = t;
        v  = iv && !r;
        tm = v && mret && !m_flush;
        ti = v && !mret && !m_flush && m_mstatus[3] && m_mie[7] && hist[0];
        e.epc = ti || tm;
        e.tgt = tm ? m_mepc : ti ? (m_mtvec & ~32'h3) + (m_mtvec[0] ? 32'd28 : 32'd0) : 32'h0;
        e.rdata = (rd && v) ? m_read(a) : 32'h0;
        q.push_back(e);
        if (r) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_flush = 0;
            hist = {1'b0, 1'b0};
        end else begin
            nv = op == 2'd1 ? wd : op == 2'd2 ? (m_read(a) | wd) : (m_read(a) & ~wd);
            m_cyc = m_cyc + 1;
            if (ti) begin
                m_mepc = p & ~32'h3;
                m_mcause = 32'h8000_0007;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (tm) begin
                m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
            end else if (v && wr && !m_flush && op != 2'd0) begin
                case (a)
                    12'h300: m_mstatus = nv & 32'h88;
                    12'h304: m_mie = nv & 32'h80;
                    12'h305: m_mtvec = nv & ~32'h2;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
`ifdef CSR_MCYCLE_EN
                    12'hB00: m_cyc[31:0] = nv;
                    12'hB80: m_cyc[63:32] = nv;
`endif
                    default: ;
                endcase
            end
            m_flush = e.epc;
            void'(hist.pop_front());
            hist.push_back(t);
        end
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests += 3;
                if (csr_rdata !== e.rdata) begin
                    fails++;
                    $display("FAIL rdata @%0t addr %h: got %h expected %h", $time, csr_addr, csr_rdata, e.rdata);
                end
                if (epc_taken !== e.epc) begin
                    fails++;
                    $display("FAIL epc_taken @%0t: got %b expected %b", $time, epc_taken, e.epc);
                end
                if (excp_pc !== e.tgt) begin
                    fails++;
                    $display("FAIL excp_pc @%0t: got %h expected %h", $time, excp_pc, e.tgt);
                end
            end
        end
    end
    initial begin
        hist = {1'b0, 1'b0};
        step(1, 0, 0, 0, 0, 0, 12'h0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0, 12'h305, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 12'h305, 0, 32'h4, 0);
        step(0, 1, 1, 0, 0, 0, 12'h300, 0, 32'h8, 0);
        step(0, 1, 0, 1, 0, 1, 12'hB80, 32'h0, 32'hC, 0);
        step(0, 1, 0, 1, 0, 1, 12'hB00, 32'hFFFF_FFFF, 32'h10, 0);
        step(0, 0, 0, 0, 0, 0, 12'h0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 12'hB80, 0, 32'h14, 0);
        step(0, 1, 1, 0, 0, 0, 12'hB00, 0, 32'h18, 0);
        step(0, 1, 1, 1, 0, 1, 12'h305, 32'h0000_0101, 32'h1C, 0);
        step(0, 1, 1, 1, 0, 2, 12'h304, 32'h80, 32'h20, 0);
        step(0, 1, 1, 1, 0, 2, 12'h300, 32'h8, 32'h24, 0);
        step(0, 0, 0, 0, 0, 0, 12'h0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 12'h344, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 12'h0, 0, 32'h40, 1);
        step(0, 1, 1, 0, 0, 0, 12'h342, 0, 32'h44, 1);
        step(0, 1, 1, 0, 0, 0, 12'h341, 0, 32'h48, 1);
        step(0, 1, 1, 0, 0, 0, 12'h300, 0, 32'h4C, 1);
        step(0, 1, 0, 0, 1, 0, 12'h0, 0, 32'h50, 1);
        step(0, 1, 1, 1, 0, 1, 12'h341, 32'h1234, 32'h54, 1);
        step(0, 1, 1, 0, 1, 0, 12'h342, 0, 32'h58, 1);
        step(0, 1, 0, 0, 0, 0, 12'h0, 0, 32'h5C, 1);
        step(0, 1, 1, 0, 0, 0, 12'h342, 0, 32'h80, 1);
        step(0, 1, 0, 0, 0, 0, 12'h0, 0, 32'h84, 1);
        step(0, 1, 0, 0, 1, 0, 12'h0, 0, 32'h88, 1);
        step(0, 1, 0, 0, 0, 0, 12'h0, 0, 32'h8C, 1);
        step(0, 1, 1, 1, 0, 3, 12'h300, 32'hFFFF_FFFF, 32'hC0, 1);
        step(0, 1, 0, 0, 0, 0, 12'h0, 0, 32'hC4, 1);
        step(0, 1, 1, 0, 0, 0, 12'h300, 0, 32'hC8, 1);
        step(0, 1, 1, 0, 0, 0, 12'h341, 0, 32'hCC, 0);
        step(0, 1, 1, 0, 0, 0, 12'h344, 0, 32'hD0, 0);
        step(0, 1, 1, 0, 0, 0, 12'h344, 0, 32'hD4, 0);
        t_lvl = 0;
        for (int i = 0; i < 600; i++) begin
            bit m, w;
            bit [31:0] wd;
            if ($urandom_range(0, 7) == 0) t_lvl = ~t_lvl;
            m = $urandom_range(0, 11) == 0;
            w = m ? 1'b0 : 1'($urandom_range(0, 1));
            wd = $urandom_range(0, 1) ? $urandom : 32'h88;
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), w, m,
                 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 9)], wd, $urandom, t_lvl);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR responder for the RV32I pipeline, sitting in the MEM stage.
- Consumes the decoder's csr_rd / csr_wr / is_mret strobes together with the CSR address, operand and PC of the instruction in MEM.
- Owns mstatus, mie, mip, mtvec, mepc and mcause; takes timer interrupts.
- Drives the trap/return redirect (epc_taken, excp_pc) to the fetch stage.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.
- IRQ_SYNC_STAGES, 2, flops synchronising timer_irq into mip.MTIP (legal values 1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  MEM-stage instruction is real (not a bubble or flushed)
- csr_rd  in  1  read CSR addressed by csr_addr
- csr_wr  in  1  write CSR addressed by csr_addr
- is_mret  in  1  instruction is MRET
- csr_op  in  2  01 = write, 10 = set, 11 = clear, 00 = none
- csr_addr  in  12  instruction[31:20]
- csr_wdata  in  32  rs1 value (forwarded)
- pc  in  32  PC of the MEM-stage instruction
- timer_irq  in  1  level timer interrupt, asynchronous to the pipeline
- csr_rdata  out  32  old CSR value for writeback (wb_sel = 11)
- epc_taken  out  1  redirect fetch this cycle
- excp_pc  out  32  redirect target

Behaviour:
- **Reset (rst = 1 at posedge):**
  - Registers: mstatus = 0, mie = 0, mtvec = RESET_MTVEC, mepc = 0, mcause = 0, sync flops = 0, FSM = RUN.
  - Outputs: epc_taken = 0, excp_pc = 0, csr_rdata = 0.
  - Reset mid-operation aborts any pending trap; no CSR update occurs that cycle.
- **Addresses:** 0x300 mstatus, 0x304 mie, 0x344 mip, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
- **Writable fields:**
  - mstatus: only MIE[3] and MPIE[7] are writable; all other bits read 0.
  - mie: only MTIE[7] is writable.
  - mip: read-only; MTIP[7] = synchronised timer_irq.
  - mtvec: bit[1] reads 0.
  - mepc: bits[1:0] read 0.
  - mcause: fully writable.
- **Read path:**
  - csr_rdata is combinational and holds the pre-write value when csr_rd & instr_valid; otherwise 0.
  - Unimplemented address: reads 0, writes ignored, no trap.
- **Write path:** on posedge when csr_wr & instr_valid & ~irq_take:
  - new = wdata (01), old | wdata (10), or old & ~wdata (11), then masked.
  - csr_op = 00 writes nothing.
- **irq_take:** instr_valid & mstatus.MIE & mie.MTIE & mip.MTIP & (state == RUN) & ~is_mret.
- **Trap entry** (irq_take, same cycle, combinational):
  - epc_taken = 1.
  - excp_pc = mtvec[31:2]<<2 if mtvec[0] = 0 (direct), else (mtvec[31:2]<<2) + 4*7 (vectored).
  - At posedge: mepc <= pc, mcause <= 32'h8000_0007, MPIE <= MIE, MIE <= 0.
  - The interrupted instruction's CSR write is suppressed; it re-executes after MRET.
- **MRET** (is_mret & instr_valid & state == RUN):
  - epc_taken = 1, excp_pc = mepc.
  - At posedge: MIE <= MPIE, MPIE <= 1.
  - MRET has priority over a simultaneous interrupt; the interrupt is taken on a later instruction if it is still pending.
- **FSM (RUN, FLUSH):**
  - RUN -> FLUSH on any epc_taken.
  - FLUSH -> RUN unconditionally after 1 cycle.
  - In FLUSH: no trap, no MRET, no CSR write (wrong-path instruction in MEM); reads still return data.
- **Interrupt latency:** timer_irq to visible MTIP is IRQ_SYNC_STAGES cycles; the trap fires on the first valid instruction after that.
- **Simultaneous csr_wr to mstatus/mie and irq_take:** irq_take is evaluated on the old register values and the write is dropped.

Optional Feature:
- Macro: CSR_MCYCLE_EN.
- **Defined:**
  - Adds 64-bit mcycle: 0xB00 low word, 0xB80 high word.
  - Increments every cycle; reset value 0; wraps 2^64-1 -> 0.
  - A CSR write to either half overrides that cycle's increment for the written half.
- **Undefined:** 0xB00 and 0xB80 behave as unimplemented (read 0, writes ignored); no counter flops are present.

Decomposition:
- **Package csr_pkg:**
  - CSR address localparams and CAUSE_M_TIMER = 32'h8000_0007.
  - Bit-index constants MIE_BIT = 3, MPIE_BIT = 7, MTIP_BIT = 7.
  - Enum csr_op_e {NONE, WRITE, SET, CLEAR}.
  - Enum trap_state_e {RUN, FLUSH}.
- **Sub-module csr_trap_fsm:** owns the RUN/FLUSH state, irq_take / mret_take arbitration, epc_taken and excp_pc selection.
- **csr_file:** instantiates csr_trap_fsm and holds the register storage and read mux.

Test Plan:
- Reset, then read 0x305 -> csr_rdata = RESET_MTVEC; read 0x300 -> 0; epc_taken = 0.
- CSRRW 0x305 with wdata 32'h0000_0101, then CSRRS 0x304 with 32'h80, then CSRRS 0x300 with 32'h8; raise timer_irq -> after 2 cycles the next valid instruction (pc 32'h40) gives epc_taken = 1, excp_pc = 32'h11C, mepc = 32'h40, mcause = 32'h8000_0007, mstatus = 32'h80.
- MRET following that trap -> epc_taken = 1, excp_pc = 32'h40, mstatus = 32'h88; next cycle in FLUSH a valid csr_wr to 0x341 is ignored.
- With the interrupt pending and MIE = 1, present MRET and the interrupt in the same cycle -> excp_pc = mepc, mcause unchanged; trap taken on the next valid instruction.
- CSRRC 0x300 with 32'hFFFF_FFFF in the same cycle irq_take fires -> trap taken, MIE cleared by the trap and MPIE = 1; the write is dropped (MPIE not cleared).
- With CSR_MCYCLE_EN: write 0xB00 = 32'hFFFF_FFFF, 0xB80 = 0 -> two cycles later the high word reads 1; without the macro, reading 0xB00 returns 0.
